// File: rtl/alu_approx_pipe_if.sv
// Operand/result handshake bundle for the pipelined approximate ALU.
// The master side is the operand source and result consumer; the slave side is the ALU.
interface alu_approx_pipe_if #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2:0]           sel;
    logic                 approx_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH:0]       y;
    logic [CNT_WIDTH-1:0] approx_cnt;

    modport master (
        output in_valid, a, b, sel, approx_en, out_ready,
        input  in_ready, out_valid, y, approx_cnt
    );

    modport slave (
        input  in_valid, a, b, sel, approx_en, out_ready,
        output in_ready, out_valid, y, approx_cnt
    );
endinterface

// File: rtl/alu_approx_pipe.sv
// Two-stage ALU with valid/ready flow control and an optional lower-part-OR approximate adder.
// S1 holds the operands, S2 holds the computed result; approx_cnt counts delivered approximate adds.
module alu_approx_pipe #(
    parameter int WIDTH       = 16,
    parameter int APPROX_BITS = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic               clk,
    input  logic               rst,
    alu_approx_pipe_if.slave   bus
);
    localparam int K   = APPROX_BITS;
    localparam int SHW = $clog2(WIDTH);

    logic                 s1_valid_reg;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [2:0]           sel_reg;
    logic                 approx_reg;

    logic                 out_valid_reg;
    logic [WIDTH:0]       y_reg;
    logic                 out_approx_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;

    logic                 s2_load;
    logic                 in_ready_int;
    logic                 in_xfer;
    logic                 out_xfer;
    logic [K-1:0]         low_or;
    logic [WIDTH-K:0]     high_sum;
    logic [SHW-1:0]       shamt;
    logic [WIDTH:0]       y_next;

    // Low part of the approximate adder: plain OR, no carry chain.
    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_low_or
            assign low_or[gi] = a_reg[gi] | b_reg[gi];
        end
    endgenerate

    // Carry into the exact upper part is guessed from the top approximate bit pair.
    assign high_sum = {1'b0, a_reg[WIDTH-1:K]} + {1'b0, b_reg[WIDTH-1:K]}
                    + {{(WIDTH-K){1'b0}}, a_reg[K-1] & b_reg[K-1]};
    assign shamt    = b_reg[SHW-1:0];

    always_comb begin
        y_next = '0;
        case (sel_reg)
            3'b000: y_next = approx_reg ? {high_sum, low_or}
                                        : ({1'b0, a_reg} + {1'b0, b_reg});
            3'b001: y_next = {(a_reg < b_reg), a_reg - b_reg};
            3'b010: y_next = {1'b0, a_reg & b_reg};
            3'b011: y_next = {1'b0, a_reg | b_reg};
            3'b100: y_next = {1'b0, a_reg ^ b_reg};
            3'b101: y_next = {1'b0, a_reg << shamt};
            3'b110: y_next = {1'b0, a_reg >> shamt};
            3'b111: y_next = {1'b0, (a_reg >= b_reg) ? a_reg : b_reg};
            default: y_next = '0;
        endcase
    end

    // S1 may refill in the same cycle it hands its operands to S2.
    assign s2_load      = s1_valid_reg & (~out_valid_reg | bus.out_ready);
    assign in_ready_int = ~s1_valid_reg | s2_load;
    assign in_xfer      = bus.in_valid & in_ready_int;
    assign out_xfer     = out_valid_reg & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            a_reg          <= '0;
            b_reg          <= '0;
            sel_reg        <= '0;
            approx_reg     <= 1'b0;
            out_valid_reg  <= 1'b0;
            y_reg          <= '0;
            out_approx_reg <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            if (in_xfer) begin
                s1_valid_reg <= 1'b1;
                a_reg        <= bus.a;
                b_reg        <= bus.b;
                sel_reg      <= bus.sel;
                approx_reg   <= bus.approx_en;
            end else if (s2_load) begin
                s1_valid_reg <= 1'b0;
            end

            if (s2_load) begin
                out_valid_reg  <= 1'b1;
                y_reg          <= y_next;
                out_approx_reg <= (sel_reg == 3'b000) & approx_reg;
            end else if (out_xfer) begin
                out_valid_reg  <= 1'b0;
            end

            if (out_xfer && out_approx_reg) begin
                cnt_reg <= cnt_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.in_ready   = in_ready_int;
    assign bus.out_valid  = out_valid_reg;
    assign bus.y          = y_reg;
    assign bus.approx_cnt = cnt_reg;
endmodule

// File: tb/tb_alu_approx_pipe.sv
// Directed bench for alu_approx_pipe (WIDTH=16, APPROX_BITS=4): inputs change just after
// the rising edge, outputs are sampled on the falling edge.
module tb_alu_approx_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_approx_pipe_if #(.WIDTH(16), .CNT_WIDTH(16)) bus ();

    alu_approx_pipe #(.WIDTH(16), .APPROX_BITS(4), .CNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready)
            $display("txn out: y=0x%05h approx_cnt=%0d", bus.y, bus.approx_cnt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input logic [15:0] av, input logic [15:0] bv,
                         input logic [2:0] s, input logic ax);
        bus.in_valid  = 1'b1;
        bus.a         = av;
        bus.b         = bv;
        bus.sel       = s;
        bus.approx_en = ax;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sel       = '0;
        bus.approx_en = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        mid();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_cnt", 32'(bus.approx_cnt), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Exact add, latency
        tick();
        drive(16'd49, 16'd13, 3'b000, 1'b0);
        tick();
        idle();
        mid();
        chk("lat_not_yet", 32'(bus.out_valid), 32'd0);
        tick();
        mid();
        chk("add_valid", 32'(bus.out_valid), 32'd1);
        chk("add_y", 32'(bus.y), 32'd62);
        chk("add_cnt", 32'(bus.approx_cnt), 32'd0);

        // Approximate vs exact 7+9
        drive(16'h0007, 16'h0009, 3'b000, 1'b1);
        tick();
        idle();
        tick();
        mid();
        chk("apx_y", 32'(bus.y), 32'h0000F);
        tick();
        mid();
        chk("apx_cnt", 32'(bus.approx_cnt), 32'd1);
        chk("apx_drained", 32'(bus.out_valid), 32'd0);
        drive(16'h0007, 16'h0009, 3'b000, 1'b0);
        tick();
        idle();
        tick();
        mid();
        chk("exa_y", 32'(bus.y), 32'h00010);
        tick();
        mid();
        chk("exa_cnt", 32'(bus.approx_cnt), 32'd1);

        // Back-to-back stream
        drive(16'd30, 16'd111, 3'b001, 1'b0);
        tick();
        drive(16'd62, 16'd3, 3'b101, 1'b0);
        mid();
        chk("b2b_empty", 32'(bus.out_valid), 32'd0);
        tick();
        drive(16'd89, 16'd11, 3'b110, 1'b0);
        mid();
        chk("b2b_sub", 32'(bus.y), 32'h1FFAF);
        chk("b2b_sub_v", 32'(bus.out_valid), 32'd1);
        tick();
        drive(16'd42, 16'd10, 3'b111, 1'b1);
        mid();
        chk("b2b_shl", 32'(bus.y), 32'd496);
        tick();
        idle();
        mid();
        chk("b2b_shr", 32'(bus.y), 32'd0);
        chk("b2b_shr_v", 32'(bus.out_valid), 32'd1);
        tick();
        mid();
        chk("b2b_max", 32'(bus.y), 32'd42);
        tick();
        mid();
        chk("b2b_done", 32'(bus.out_valid), 32'd0);
        chk("b2b_cnt", 32'(bus.approx_cnt), 32'd1);

        // Stall with three offered operations
        bus.out_ready = 1'b0;
        drive(16'h00F0, 16'h0FF0, 3'b010, 1'b0);
        tick();
        drive(16'h0F00, 16'h00F0, 3'b011, 1'b0);
        mid();
        chk("stl_rdy1", 32'(bus.in_ready), 32'd1);
        tick();
        drive(16'hFF00, 16'h0FF0, 3'b100, 1'b0);
        mid();
        chk("stl_rdy0", 32'(bus.in_ready), 32'd0);
        chk("stl_y_a", 32'(bus.y), 32'h000F0);
        tick();
        mid();
        chk("stl_hold_rdy", 32'(bus.in_ready), 32'd0);
        chk("stl_hold_y", 32'(bus.y), 32'h000F0);
        chk("stl_hold_v", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        #1;
        chk("stl_release_rdy", 32'(bus.in_ready), 32'd1);
        tick();
        idle();
        mid();
        chk("stl_y_b", 32'(bus.y), 32'h00FF0);
        tick();
        mid();
        chk("stl_y_c", 32'(bus.y), 32'h0F0F0);
        tick();
        mid();
        chk("stl_done", 32'(bus.out_valid), 32'd0);

        // Approximate adder carry guess boundaries
        drive(16'hFFF7, 16'h0008, 3'b000, 1'b1);
        tick();
        drive(16'hFFFF, 16'h0008, 3'b000, 1'b1);
        tick();
        drive(16'hFFFF, 16'h0008, 3'b000, 1'b0);
        mid();
        chk("apx_cin0", 32'(bus.y), 32'h0FFFF);
        tick();
        idle();
        mid();
        chk("apx_cin1", 32'(bus.y), 32'h1000F);
        tick();
        mid();
        chk("exa_carry", 32'(bus.y), 32'h10007);
        tick();
        mid();
        chk("apx_cnt3", 32'(bus.approx_cnt), 32'd3);

        // Reset with two operations in flight
        bus.out_ready = 1'b0;
        drive(16'd1, 16'd2, 3'b000, 1'b1);
        tick();
        drive(16'd3, 16'd4, 3'b000, 1'b1);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mid();
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_rdy", 32'(bus.in_ready), 32'd1);
        chk("mrst_cnt", 32'(bus.approx_cnt), 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            mid();
            chk("mrst_no_stale", 32'(bus.out_valid), 32'd0);
        end

        // approx_en ignored for non-add operations
        drive(16'h1234, 16'h00FF, 3'b010, 1'b1);
        tick();
        idle();
        tick();
        mid();
        chk("ign_y", 32'(bus.y), 32'h00034);
        tick();
        mid();
        chk("ign_cnt", 32'(bus.approx_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
